tile_tl_quiesce_buffer: RTL and testbench

TILE_TL_QUIESCE_BUFFER -- requirements
Module: tile_tl_quiesce_buffer

---
 rtl/tile_tl_pkg.sv | 56 +++++
 rtl/tl_beat_queue.sv | 60 ++++++
 rtl/tile_tl_quiesce_buffer.sv | 183 ++++++++++++++++++
 tb/tb_tile_tl_quiesce_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_tl_pkg.sv
// Shared TileLink types for the tile quiesce buffer: opcodes, beat payloads,
// buffer state and the beats-per-message helper.
package tile_tl_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_ARITHMETIC      = 3'd2;
  localparam logic [2:0] A_LOGICAL         = 3'd3;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [2:0]  sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } d_beat_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_e;

  function automatic logic a_has_data(input logic [2:0] op);
    return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) ||
           (op == A_ARITHMETIC) || (op == A_LOGICAL);
  endfunction

  function automatic logic d_has_data(input logic [2:0] op);
    return (op == D_ACCESS_ACK_DATA) || (op == D_GRANT_DATA);
  endfunction

  // 64-bit beats: a data message of 2^size bytes spans 2^(size-3) beats.
  function automatic logic [12:0] tl_beats(input logic has_data, input logic [3:0] size);
    if (has_data && (size > 4'd3)) begin
      return 13'd1 << (size - 4'd3);
    end
    return 13'd1;
  endfunction

endpackage

// File: rtl/tl_beat_queue.sv
// Registered-output beat FIFO; no combinational path from input to output side.
// Ready is held low until the first clock edge after reset release.
module tl_beat_queue #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_bits,
  output logic out_valid,
  input  logic out_ready,
  output T     out_bits
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            alive_q;
  logic            push, pop;

  assign in_ready  = alive_q && (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_bits  = out_valid ? mem_q[rptr_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
    end
  end

  // Storage is data only; emptiness masks stale entries on the output.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= in_bits;
  end

endmodule

// File: rtl/tile_tl_quiesce_buffer.sv
// Tile-side TileLink A/D buffer that tracks in-flight sources, flags protocol
// errors and can drain the tile to a quiesced state on request.
module tile_tl_quiesce_buffer
  import tile_tl_pkg::*;
#(
  parameter int DEPTH_A = 2,
  parameter int DEPTH_D = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_a_valid,
  output logic        in_a_ready,
  input  logic [2:0]  in_a_bits_opcode,
  input  logic [2:0]  in_a_bits_param,
  input  logic [3:0]  in_a_bits_size,
  input  logic [1:0]  in_a_bits_source,
  input  logic [31:0] in_a_bits_address,
  input  logic [7:0]  in_a_bits_mask,
  input  logic [63:0] in_a_bits_data,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_bits_opcode,
  output logic [2:0]  out_a_bits_param,
  output logic [3:0]  out_a_bits_size,
  output logic [1:0]  out_a_bits_source,
  output logic [31:0] out_a_bits_address,
  output logic [7:0]  out_a_bits_mask,
  output logic [63:0] out_a_bits_data,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_bits_opcode,
  input  logic [1:0]  out_d_bits_param,
  input  logic [3:0]  out_d_bits_size,
  input  logic [1:0]  out_d_bits_source,
  input  logic [2:0]  out_d_bits_sink,
  input  logic        out_d_bits_denied,
  input  logic [63:0] out_d_bits_data,
  input  logic        out_d_bits_corrupt,
  output logic        in_d_valid,
  input  logic        in_d_ready,
  output logic [2:0]  in_d_bits_opcode,
  output logic [1:0]  in_d_bits_param,
  output logic [3:0]  in_d_bits_size,
  output logic [1:0]  in_d_bits_source,
  output logic [2:0]  in_d_bits_sink,
  output logic        in_d_bits_denied,
  output logic [63:0] in_d_bits_data,
  output logic        in_d_bits_corrupt,
  input  logic        quiesce_req,
  output logic        quiesced,
  output logic [1:0]  err
);

  a_beat_t     a_in_beat, a_out_beat;
  d_beat_t     d_in_beat, d_out_beat;
  state_e      state_q, state_d;
  logic [11:0] a_in_cnt_q, a_in_cnt_d;
  logic [11:0] a_out_cnt_q, a_out_cnt_d;
  logic [11:0] d_cnt_q, d_cnt_d;
  logic [3:0]  inflight_q, inflight_d, inflight_set, inflight_clr;
  logic [1:0]  err_q, err_d;
  logic        run, a_q_ready;
  logic        a_in_fire, a_out_fire, d_bus_fire;
  logic        a_in_last, a_out_last, d_last;

  assign a_in_beat = '{opcode: in_a_bits_opcode, param: in_a_bits_param, size: in_a_bits_size,
                       source: in_a_bits_source, address: in_a_bits_address,
                       mask: in_a_bits_mask, data: in_a_bits_data};
  assign d_in_beat = '{opcode: out_d_bits_opcode, param: out_d_bits_param, size: out_d_bits_size,
                       source: out_d_bits_source, sink: out_d_bits_sink,
                       denied: out_d_bits_denied, data: out_d_bits_data,
                       corrupt: out_d_bits_corrupt};

  assign run        = (state_q == ST_RUN);
  assign in_a_ready = a_q_ready && run;

  tl_beat_queue #(.DEPTH(DEPTH_A), .T(a_beat_t)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid && run),
    .in_ready  (a_q_ready),
    .in_bits   (a_in_beat),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_bits  (a_out_beat)
  );

  tl_beat_queue #(.DEPTH(DEPTH_D), .T(d_beat_t)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (out_d_valid),
    .in_ready  (out_d_ready),
    .in_bits   (d_in_beat),
    .out_valid (in_d_valid),
    .out_ready (in_d_ready),
    .out_bits  (d_out_beat)
  );

  assign out_a_bits_opcode  = a_out_beat.opcode;
  assign out_a_bits_param   = a_out_beat.param;
  assign out_a_bits_size    = a_out_beat.size;
  assign out_a_bits_source  = a_out_beat.source;
  assign out_a_bits_address = a_out_beat.address;
  assign out_a_bits_mask    = a_out_beat.mask;
  assign out_a_bits_data    = a_out_beat.data;
  assign in_d_bits_opcode   = d_out_beat.opcode;
  assign in_d_bits_param    = d_out_beat.param;
  assign in_d_bits_size     = d_out_beat.size;
  assign in_d_bits_source   = d_out_beat.source;
  assign in_d_bits_sink     = d_out_beat.sink;
  assign in_d_bits_denied   = d_out_beat.denied;
  assign in_d_bits_data     = d_out_beat.data;
  assign in_d_bits_corrupt  = d_out_beat.corrupt;

  assign a_in_fire  = in_a_valid && in_a_ready;
  assign a_out_fire = out_a_valid && out_a_ready;
  assign d_bus_fire = out_d_valid && out_d_ready;

  assign a_in_last  = ({1'b0, a_in_cnt_q} ==
                       tl_beats(a_has_data(in_a_bits_opcode), in_a_bits_size) - 13'd1);
  assign a_out_last = ({1'b0, a_out_cnt_q} ==
                       tl_beats(a_has_data(a_out_beat.opcode), a_out_beat.size) - 13'd1);
  assign d_last     = ({1'b0, d_cnt_q} ==
                       tl_beats(d_has_data(out_d_bits_opcode), out_d_bits_size) - 13'd1);

  always_comb begin
    a_in_cnt_d  = a_in_fire  ? (a_in_last  ? '0 : a_in_cnt_q  + 12'd1) : a_in_cnt_q;
    a_out_cnt_d = a_out_fire ? (a_out_last ? '0 : a_out_cnt_q + 12'd1) : a_out_cnt_q;
    d_cnt_d     = d_bus_fire ? (d_last     ? '0 : d_cnt_q     + 12'd1) : d_cnt_q;
  end

  // A set and a clear on the same source in one cycle leaves it in flight.
  always_comb begin
    inflight_set = '0;
    inflight_clr = '0;
    err_d        = err_q;
    if (a_out_fire && (a_out_cnt_q == '0) && inflight_q[a_out_beat.source]) err_d[0] = 1'b1;
    if (d_bus_fire && (d_cnt_q == '0) && !inflight_q[out_d_bits_source])     err_d[1] = 1'b1;
    if (a_out_fire && a_out_last) inflight_set[a_out_beat.source] = 1'b1;
    if (d_bus_fire && d_last)     inflight_clr[out_d_bits_source] = 1'b1;
    inflight_d = (inflight_q & ~inflight_clr) | inflight_set;
  end

  // Using the next A count lets a message that is finishing this cycle enter DRAIN at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (quiesce_req && (a_in_cnt_d == '0)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!quiesce_req) state_d = ST_RUN;
        else if (!out_a_valid && !in_d_valid && (inflight_q == '0)) state_d = ST_QUIESCED;
      end
      ST_QUIESCED: begin
        if (!quiesce_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      a_in_cnt_q  <= '0;
      a_out_cnt_q <= '0;
      d_cnt_q     <= '0;
      inflight_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_in_cnt_q  <= a_in_cnt_d;
      a_out_cnt_q <= a_out_cnt_d;
      d_cnt_q     <= d_cnt_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign quiesced = (state_q == ST_QUIESCED);
  assign err      = err_q;

endmodule

// File: tb/tb_tile_tl_quiesce_buffer.sv
// Bench for tile_tl_quiesce_buffer: message-level scoreboard of both channels
// plus directed scenarios with literal expectations.
module tb_tile_tl_quiesce_buffer;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } abeat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [2:0]  sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } dbeat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_a_valid = 1'b0, in_a_ready;
  logic [2:0]  in_a_bits_opcode = '0, in_a_bits_param = '0;
  logic [3:0]  in_a_bits_size = '0;
  logic [1:0]  in_a_bits_source = '0;
  logic [31:0] in_a_bits_address = '0;
  logic [7:0]  in_a_bits_mask = '0;
  logic [63:0] in_a_bits_data = '0;
  logic        out_a_valid, out_a_ready = 1'b0;
  logic [2:0]  out_a_bits_opcode, out_a_bits_param;
  logic [3:0]  out_a_bits_size;
  logic [1:0]  out_a_bits_source;
  logic [31:0] out_a_bits_address;
  logic [7:0]  out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic        out_d_valid = 1'b0, out_d_ready;
  logic [2:0]  out_d_bits_opcode = '0;
  logic [1:0]  out_d_bits_param = '0;
  logic [3:0]  out_d_bits_size = '0;
  logic [1:0]  out_d_bits_source = '0;
  logic [2:0]  out_d_bits_sink = '0;
  logic        out_d_bits_denied = 1'b0;
  logic [63:0] out_d_bits_data = '0;
  logic        out_d_bits_corrupt = 1'b0;
  logic        in_d_valid, in_d_ready = 1'b0;
  logic [2:0]  in_d_bits_opcode;
  logic [1:0]  in_d_bits_param;
  logic [3:0]  in_d_bits_size;
  logic [1:0]  in_d_bits_source;
  logic [2:0]  in_d_bits_sink;
  logic        in_d_bits_denied;
  logic [63:0] in_d_bits_data;
  logic        in_d_bits_corrupt;
  logic        quiesce_req = 1'b0, quiesced;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  tile_tl_quiesce_buffer #(.DEPTH_A(2), .DEPTH_D(2)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_param(in_a_bits_param),
    .in_a_bits_size(in_a_bits_size), .in_a_bits_source(in_a_bits_source),
    .in_a_bits_address(in_a_bits_address), .in_a_bits_mask(in_a_bits_mask),
    .in_a_bits_data(in_a_bits_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
    .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
    .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
    .out_a_bits_data(out_a_bits_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
    .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
    .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_bits_opcode(in_d_bits_opcode), .in_d_bits_param(in_d_bits_param),
    .in_d_bits_size(in_d_bits_size), .in_d_bits_source(in_d_bits_source),
    .in_d_bits_sink(in_d_bits_sink), .in_d_bits_denied(in_d_bits_denied),
    .in_d_bits_data(in_d_bits_data), .in_d_bits_corrupt(in_d_bits_corrupt),
    .quiesce_req(quiesce_req), .quiesced(quiesced), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int nbeats(input bit has_data, input logic [3:0] sz);
    if (has_data && sz > 4'd3) return 1 << (sz - 4'd3);
    return 1;
  endfunction

  // ---------------- message-level reference model ----------------
  abeat_t a_exp[$];
  dbeat_t d_exp[$];
  abeat_t a_cur, a_pop, a_push;
  dbeat_t d_cur, d_pop, d_push;
  int     a_rem = 0, d_rem = 0, a_pops = 0;
  logic [3:0] infl_m = '0, set_m, clr_m;
  logic [1:0] err_m = '0;

  assign a_cur = '{out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source,
                   out_a_bits_address, out_a_bits_mask, out_a_bits_data};
  assign d_cur = '{in_d_bits_opcode, in_d_bits_param, in_d_bits_size, in_d_bits_source,
                   in_d_bits_sink, in_d_bits_denied, in_d_bits_data, in_d_bits_corrupt};

  always @(negedge clock) begin
    if (!reset) begin
      a_exp.delete();
      d_exp.delete();
      a_rem  = 0;
      d_rem  = 0;
      infl_m = '0;
      err_m  = '0;
    end else begin
      check("a_valid", out_a_valid, a_exp.size() != 0);
      if (a_exp.size() != 0) check("a_bits", a_cur, a_exp[0]);
      check("d_valid", in_d_valid, d_exp.size() != 0);
      if (d_exp.size() != 0) check("d_bits", d_cur, d_exp[0]);
      check("d_ready", out_d_ready, d_exp.size() < 2);
      check("err", err, err_m);
      if (a_exp.size() >= 2) check("a_ready_full", in_a_ready, 1'b0);
      set_m = '0;
      clr_m = '0;
      if (out_a_valid && out_a_ready && a_exp.size() != 0) begin
        a_pop = a_exp.pop_front();
        a_pops++;
        if (a_rem == 0) begin
          if (infl_m[a_pop.source]) err_m[0] = 1'b1;
          a_rem = nbeats(a_pop.opcode <= 3'd3, a_pop.size);
        end
        a_rem--;
        if (a_rem == 0) set_m[a_pop.source] = 1'b1;
      end
      if (out_d_valid && out_d_ready) begin
        d_push = '{out_d_bits_opcode, out_d_bits_param, out_d_bits_size, out_d_bits_source,
                   out_d_bits_sink, out_d_bits_denied, out_d_bits_data, out_d_bits_corrupt};
        d_exp.push_back(d_push);
        if (d_rem == 0) begin
          if (!infl_m[d_push.source]) err_m[1] = 1'b1;
          d_rem = nbeats(d_push.opcode == 3'd1 || d_push.opcode == 3'd5, d_push.size);
        end
        d_rem--;
        if (d_rem == 0) clr_m[d_push.source] = 1'b1;
      end
      infl_m = (infl_m & ~clr_m) | set_m;
      if (in_d_valid && in_d_ready && d_exp.size() != 0) void'(d_exp.pop_front());
      if (in_a_valid && in_a_ready) begin
        a_push = '{in_a_bits_opcode, in_a_bits_param, in_a_bits_size, in_a_bits_source,
                   in_a_bits_address, in_a_bits_mask, in_a_bits_data};
        a_exp.push_back(a_push);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [31:0] addr, input logic [63:0] data);
    bit fired = 0;
    in_a_valid = 1'b1;
    in_a_bits_opcode = op;  in_a_bits_param = 3'd0; in_a_bits_size = sz;
    in_a_bits_source = src; in_a_bits_address = addr; in_a_bits_mask = 8'hFF;
    in_a_bits_data = data;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clock);
      fired = in_a_ready;
      tick();
    end
    in_a_valid = 1'b0;
    if (!fired) check("a_send_timeout", fired, 1'b1);
  endtask

  task automatic send_d(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [63:0] data);
    bit fired = 0;
    out_d_valid = 1'b1;
    out_d_bits_opcode = op; out_d_bits_param = 2'd0; out_d_bits_size = sz;
    out_d_bits_source = src; out_d_bits_sink = 3'd2; out_d_bits_denied = 1'b0;
    out_d_bits_data = data; out_d_bits_corrupt = 1'b0;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clock);
      fired = out_d_ready;
      tick();
    end
    out_d_valid = 1'b0;
    if (!fired) check("d_send_timeout", fired, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (!out_a_valid && !in_d_valid) break;
      tick();
    end
    check("drain_timeout", {out_a_valid, in_d_valid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_in_a_ready", in_a_ready, 1'b0);
    check("rst_out_d_ready", out_d_ready, 1'b0);
    check("rst_out_a_valid", out_a_valid, 1'b0);
    check("rst_in_d_valid", in_d_valid, 1'b0);
    check("rst_quiesced", quiesced, 1'b0);
    check("rst_err", err, 2'b00);
    check("rst_a_data", out_a_bits_data, 64'h0);
    @(negedge clock);
    #1 reset = 1'b1;
    tick();
    check("post_rst_in_a_ready", in_a_ready, 1'b1);
    check("post_rst_out_d_ready", out_d_ready, 1'b1);

    // Single Get, source 1
    in_d_ready = 1'b1;
    check("get_pre_valid", out_a_valid, 1'b0);
    send_a(3'd4, 4'd3, 2'd1, 32'h0000_1000, 64'h0);
    check("get_latency_valid", out_a_valid, 1'b1);
    check("get_addr", out_a_bits_address, 32'h0000_1000);
    out_a_ready = 1'b1;
    tick();
    check("get_popped", out_a_valid, 1'b0);
    send_d(3'd1, 4'd3, 2'd1, 64'hDEAD_BEEF_0123_4567);
    check("ackdata_valid", in_d_valid, 1'b1);
    check("ackdata_src", in_d_bits_source, 2'd1);
    check("ackdata_data", in_d_bits_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("ackdata_popped", in_d_valid, 1'b0);
    check("get_err", err, 2'b00);

    // Nothing in flight: quiesce completes two edges after the request
    quiesce_req = 1'b1;
    tick();
    check("q1_in_a_ready", in_a_ready, 1'b0);
    check("q1_quiesced", quiesced, 1'b0);
    tick();
    check("q1_quiesced_set", quiesced, 1'b1);
    quiesce_req = 1'b0;
    tick();
    check("q1_release_quiesced", quiesced, 1'b0);
    check("q1_release_ready", in_a_ready, 1'b1);

    // 8-beat PutFull with back-pressure
    out_a_ready = 1'b0;
    base = a_pops;
    send_a(3'd0, 4'd6, 2'd0, 32'h0000_2000, 64'hA5A5_0000_0000_0000);
    send_a(3'd0, 4'd6, 2'd0, 32'h0000_2000, 64'hA5A5_0000_0000_0001);
    check("put_full_ready", in_a_ready, 1'b0);
    out_a_ready = 1'b1;
    for (int i = 2; i < 8; i++) send_a(3'd0, 4'd6, 2'd0, 32'h0000_2000, 64'hA5A5_0000_0000_0000 | 64'(i));
    drain();
    check("put_beats_out", a_pops - base, 8);
    send_d(3'd0, 4'd6, 2'd0, 64'h0);
    drain();

    // Quiesce raised mid-message
    for (int i = 0; i < 8; i++) begin
      send_a(3'd0, 4'd6, 2'd0, 32'h0000_3000, 64'hC0DE_0000_0000_0000 | 64'(i));
      if (i == 2) quiesce_req = 1'b1;
    end
    check("q2_in_a_ready_closed", in_a_ready, 1'b0);
    drain();
    tick();
    check("q2_wait_ack_quiesced", quiesced, 1'b0);
    send_d(3'd0, 4'd6, 2'd0, 64'h0);
    check("q2_ack_queued", in_d_valid, 1'b1);
    tick();
    check("q2_ack_drained_quiesced", quiesced, 1'b0);
    tick();
    check("q2_quiesced", quiesced, 1'b1);
    quiesce_req = 1'b0;
    tick();
    check("q2_release_quiesced", quiesced, 1'b0);
    check("q2_release_ready", in_a_ready, 1'b1);

    // Protocol errors
    send_a(3'd4, 4'd3, 2'd2, 32'h0000_4000, 64'h0);
    drain();
    check("err_first_get", err, 2'b00);
    send_a(3'd4, 4'd3, 2'd2, 32'h0000_4008, 64'h0);
    drain();
    check("err_dup_source", err, 2'b01);
    send_d(3'd1, 4'd3, 2'd3, 64'h1111);
    drain();
    check("err_unsolicited", err, 2'b11);
    send_d(3'd1, 4'd3, 2'd2, 64'h2222);
    drain();
    repeat (2) tick();
    check("err_sticky", err, 2'b11);

    // Reset with traffic queued on both paths
    out_a_ready = 1'b0;
    in_d_ready  = 1'b0;
    send_a(3'd0, 4'd4, 2'd1, 32'h0000_5000, 64'h5555);
    send_a(3'd0, 4'd4, 2'd1, 32'h0000_5000, 64'h6666);
    send_d(3'd1, 4'd4, 2'd0, 64'h7777);
    send_d(3'd1, 4'd4, 2'd0, 64'h8888);
    check("pre_rst_a_full", in_a_ready, 1'b0);
    check("pre_rst_d_full", out_d_ready, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_out_a_valid", out_a_valid, 1'b0);
    check("mid_rst_in_d_valid", in_d_valid, 1'b0);
    check("mid_rst_in_a_ready", in_a_ready, 1'b0);
    check("mid_rst_out_d_ready", out_d_ready, 1'b0);
    check("mid_rst_err", err, 2'b00);
    check("mid_rst_a_data", out_a_bits_data, 64'h0);
    check("mid_rst_d_data", in_d_bits_data, 64'h0);
    repeat (2) tick();
    @(negedge clock);
    #1 reset = 1'b1;
    tick();
    check("rel_in_a_ready", in_a_ready, 1'b1);
    check("rel_out_d_ready", out_d_ready, 1'b1);
    check("rel_out_a_valid", out_a_valid, 1'b0);
    check("rel_in_d_valid", in_d_valid, 1'b0);
    check("rel_quiesced", quiesced, 1'b0);
    check("rel_err", err, 2'b00);

    // Traffic flows again after reset
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    send_a(3'd4, 4'd3, 2'd3, 32'h0000_6000, 64'h0);
    drain();
    send_d(3'd1, 4'd3, 2'd3, 64'h9999);
    drain();
    tick();
    check("final_err", err, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
